piece_rng_bag: RTL and testbench
================================

Name: piece_rng_bag

Overview:
- Parametrised successor to the 2-bit free-running piece randomiser.
- Free-running Galois LFSR, with optional mixing of user-input entropy.
- Returns one tetromino index per request over a req/valid handshake.
- Two runtime modes:
  - uniform mode: any legal index can be returned, including repeats.
  - bag mode: every index 0..NUM_PIECES-1 appears exactly once per bag before any repeats.
- Sits between the controller's "spawn next piece" request and the piece-spawn datapath.

Parameters:
LFSR_W, 16, LFSR width; feedback polynomial x^16+x^14+x^13+x^11+1 (Galois mask 16'hB400); fixed for width 16.
SEED, 16'hACE1, nonzero LFSR load value on restart and on lockup.
NUM_PIECES, 7, number of legal piece indices (2..2^PIECE_W).
PIECE_W, 3, width of piece index.
ENT_W, 4, width of entropy input; ENT_W <= LFSR_W.

Ports:
clka  in  1  clock; all logic on posedge clka.
restart  in  1  synchronous active-high reset.
mode  in  1  0 = uniform, 1 = bag (no repeats within a bag).
next_req  in  1  request a new piece; sampled only in IDLE.
entropy_strobe  in  1  XOR entropy_in into LFSR this cycle.
entropy_in  in  ENT_W  user-input derived bits (button states).
piece  out  PIECE_W  last issued index; holds between issues.
piece_valid  out  1  one-cycle pulse when piece updates.
busy  out  1  high while in SCAN.
bag_count  out  PIECE_W  pieces already drawn from current bag.
lfsr_state  out  LFSR_W  current LFSR value (verification visibility).

Behaviour:
- Reset (restart=1 at posedge) outputs:
  - lfsr_state=SEED, piece=0, piece_valid=0, busy=0, bag_count=0.
  - used mask=0; FSM=IDLE.
  - restart overrides every other input, including mid-SCAN; any pending request is dropped.
- LFSR steps every non-reset cycle:
  - nxt = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - If entropy_strobe: nxt ^= zero-extended entropy_in.
  - If nxt==0: load SEED instead (lockup guard).
- FSM states: IDLE, SCAN.
- IDLE:
  - next_req=1 -> cand <= lfsr_state[PIECE_W-1:0] (pre-step value); go to SCAN; busy=1 from the next cycle.
  - next_req=0 -> stay in IDLE.
- SCAN, each cycle: cand is acceptable iff cand < NUM_PIECES and (mode==0 or used[cand]==0).
  - Acceptable:
    - piece <= cand; piece_valid <= 1 for exactly one cycle.
    - If mode==1: set used[cand].
    - Go to IDLE.
  - Not acceptable:
    - cand <= (cand >= NUM_PIECES-1) ? 0 : cand+1.
    - Stay in SCAN.
- Latency:
  - req sampled at edge k -> piece_valid high after edge k+1 at best.
  - Worst case after edge k+2^PIECE_W.
  - busy is never high for more than 2^PIECE_W cycles.
- next_req while busy=1, or in the same cycle piece_valid is high, is ignored (not queued).
- Bag bookkeeping:
  - bag_count = popcount(used).
  - When setting used[cand] would make all NUM_PIECES bits set, used clears to 0 in that same edge, so bag_count returns to 0 and the next bag starts with the following request.
  - In mode 0, used and bag_count are frozen (not cleared).
- Mode may change at any cycle; it is evaluated per SCAN cycle. Switching 1->0 keeps the used mask for later bag-mode use.
- entropy_strobe is honoured in every state, including SCAN and the restart-release cycle. It is not honoured while restart=1.
- Reset mid-SCAN: no piece_valid pulse is produced for the aborted request.

Test Plan:
- Reset: hold restart 3 cycles, release.
  - While held: lfsr_state=16'hACE1, all outputs 0.
  - After release with no strobe: lfsr_state matches the bench's Galois reference model every cycle for 1000 cycles.
- Bag mode: mode=1, issue 70 requests each waiting for piece_valid.
  - Each aligned group of 7 pieces is a permutation of 0..6.
  - bag_count steps 1..6 then 0.
  - busy never exceeds 8 cycles.
- Uniform mode: mode=0, 500 requests.
  - Every piece < 7; every index 0..6 occurs at least once.
  - bag_count stays at its pre-switch value.
  - Latency for each request is 2..9 edges.
- Busy/overlap: pulse next_req, then hold it high 10 cycles.
  - Exactly one piece_valid per acceptance.
  - Requests during busy are dropped.
  - No second pulse in the same cycle as piece_valid.
- Restart mid-operation: assert restart during SCAN after 3 bag draws.
  - No piece_valid; bag_count=0; lfsr_state=16'hACE1.
  - The next 7 draws form a full permutation.
- Entropy/lockup: entropy_strobe with entropy_in chosen so nxt==0.
  - lfsr_state becomes 16'hACE1.
  - Nonzero entropy XOR matches the reference model.
  - lfsr_state never observed 0 over a 70000-cycle run.

Source files
------------

// File: rtl/piece_rng_bag.sv
// Tetromino index generator: free-running Galois LFSR with entropy mixing,
// uniform or bag (no repeats within a bag) draw over a req/valid handshake.
module piece_rng_bag #(
  parameter int unsigned          LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]    SEED       = 16'hACE1,
  parameter int unsigned          NUM_PIECES = 7,
  parameter int unsigned          PIECE_W    = 3,
  parameter int unsigned          ENT_W      = 4
) (
  input  logic               clka,
  input  logic               restart,
  input  logic               mode,
  input  logic               next_req,
  input  logic               entropy_strobe,
  input  logic [ENT_W-1:0]   entropy_in,
  output logic [PIECE_W-1:0] piece,
  output logic               piece_valid,
  output logic               busy,
  output logic [PIECE_W-1:0] bag_count,
  output logic [LFSR_W-1:0]  lfsr_state
);

  localparam int unsigned        SLOTS = 1 << PIECE_W;
  localparam logic [LFSR_W-1:0]  POLY  = LFSR_W'(16'hB400);
  localparam logic [PIECE_W-1:0] LAST  = PIECE_W'(NUM_PIECES - 1);
  localparam logic [SLOTS-1:0]   FULL  = SLOTS'((64'd1 << NUM_PIECES) - 64'd1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t             r_state, w_state_nxt;
  logic [LFSR_W-1:0]  r_lfsr, w_lfsr_nxt;
  logic [PIECE_W-1:0] r_cand, w_cand_nxt;
  logic [SLOTS-1:0]   r_used, w_used_nxt;
  logic [PIECE_W-1:0] r_piece, w_piece_nxt;
  logic               r_piece_valid, w_valid_nxt;
  logic               r_busy;
  logic [PIECE_W-1:0] r_bag_count, w_pop;
  logic [SLOTS-1:0]   w_set;
  logic               w_in_range;
  logic               w_accept;

  // Galois step, entropy mix, then lockup guard (zero state reloads SEED).
  always_comb begin
    w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? POLY : '0);
    if (entropy_strobe) w_lfsr_nxt = w_lfsr_nxt ^ LFSR_W'(entropy_in);
    if (w_lfsr_nxt == '0) w_lfsr_nxt = SEED;
  end

  assign w_in_range = 32'(r_cand) < NUM_PIECES;
  assign w_accept   = w_in_range && (!mode || !r_used[r_cand]);
  assign w_set      = r_used | (SLOTS'(1) << r_cand);

  // Next-state: IDLE captures a candidate, SCAN walks it forward until legal.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_used_nxt  = r_used;
    w_piece_nxt = r_piece;
    w_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (next_req && !r_piece_valid) begin
          w_cand_nxt  = r_lfsr[PIECE_W-1:0];
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_accept) begin
          w_piece_nxt = r_cand;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
          if (mode) w_used_nxt = ((w_set & FULL) == FULL) ? '0 : w_set;
        end else begin
          w_cand_nxt = (r_cand >= LAST) ? '0 : r_cand + PIECE_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < SLOTS; i++) w_pop = w_pop + PIECE_W'(w_used_nxt[i]);
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      r_state       <= ST_IDLE;
      r_lfsr        <= SEED;
      r_cand        <= '0;
      r_used        <= '0;
      r_piece       <= '0;
      r_piece_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_bag_count   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_lfsr        <= w_lfsr_nxt;
      r_cand        <= w_cand_nxt;
      r_used        <= w_used_nxt;
      r_piece       <= w_piece_nxt;
      r_piece_valid <= w_valid_nxt;
      r_busy        <= (w_state_nxt == ST_SCAN);
      r_bag_count   <= w_pop;
    end
  end

  assign piece       = r_piece;
  assign piece_valid = r_piece_valid;
  assign busy        = r_busy;
  assign bag_count   = r_bag_count;
  assign lfsr_state  = r_lfsr;

endmodule

// File: tb/tb_piece_rng_bag.sv
// Self-checking bench for piece_rng_bag against a behavioural draw/LFSR model.
module tb_piece_rng_bag;

  localparam int unsigned NP   = 7;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clka = 1'b0;
  logic        restart, mode, next_req, entropy_strobe;
  logic [3:0]  entropy_in;
  logic [2:0]  piece, bag_count;
  logic        piece_valid, busy;
  logic [15:0] lfsr_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mdl_lfsr;
  bit          mdl_used [NP];

  always #5 clka = ~clka;

  piece_rng_bag dut (
    .clka(clka), .restart(restart), .mode(mode), .next_req(next_req),
    .entropy_strobe(entropy_strobe), .entropy_in(entropy_in),
    .piece(piece), .piece_valid(piece_valid), .busy(busy),
    .bag_count(bag_count), .lfsr_state(lfsr_state)
  );

  function automatic logic [15:0] galois(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] mdl_next(input logic [15:0] x, input logic stb, input logic [3:0] ent);
    logic [15:0] n;
    n = galois(x) ^ (stb ? {12'h000, ent} : 16'h0000);
    return (n == 16'h0000) ? SEED : n;
  endfunction

  always @(posedge clka) mdl_lfsr <= restart ? SEED : mdl_next(mdl_lfsr, entropy_strobe, entropy_in);

  function automatic int mdl_pop();
    int n = 0;
    for (int i = 0; i < NP; i++) n += int'(mdl_used[i]);
    return n;
  endfunction

  // Walk from the captured candidate to the first legal index; returns SCAN cycles.
  function automatic int scan_steps(input logic [2:0] c0, input logic m, output logic [2:0] pc);
    int c = int'(c0);
    int s = 1;
    while (!(c < NP && (!m || !mdl_used[c]))) begin
      c = (c >= NP - 1) ? 0 : c + 1;
      s++;
    end
    pc = 3'(c);
    return s;
  endfunction

  task automatic mdl_take(input logic [2:0] p);
    mdl_used[p] = 1'b1;
    if (mdl_pop() == NP) for (int i = 0; i < NP; i++) mdl_used[i] = 1'b0;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NP; i++) mdl_used[i] = 1'b0;
  endtask

  task automatic rand_strobe();
    entropy_strobe = ($urandom_range(0, 3) == 0);
    entropy_in     = 4'($urandom);
  endtask

  // One request with random idle gap and random entropy; returns observed and expected results.
  task automatic do_req(input logic m, output logic [2:0] got, output int lat,
                        output logic [2:0] ep, output int el, output bit busy_ok);
    int gap = $urandom_range(1, 3);
    repeat (gap) begin
      @(negedge clka);
      rand_strobe();
    end
    el = scan_steps(mdl_lfsr[2:0], m, ep) + 1;
    next_req = 1'b1;
    @(negedge clka);
    next_req = 1'b0;
    rand_strobe();
    lat = 1;
    busy_ok = (busy === 1'b1);
    while (piece_valid !== 1'b1 && lat < 20) begin
      @(negedge clka);
      rand_strobe();
      lat++;
      if (piece_valid !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    got = piece;
    entropy_strobe = 1'b0;
    if (m) mdl_take(ep);
  endtask

  task automatic test_reset();
    restart = 1'b1; mode = 1'b0; next_req = 1'b0; entropy_strobe = 1'b0; entropy_in = 4'h0;
    mdl_clear();
    repeat (3) begin
      @(negedge clka);
      n_checks++; if (lfsr_state !== SEED) $display("FAIL reset_lfsr got=%h exp=%h", lfsr_state, SEED); else n_pass++;
      n_checks++; if ({piece, piece_valid, busy, bag_count} !== 8'h00)
        $display("FAIL reset_outputs got piece=%0d pv=%b busy=%b bag=%0d exp all 0", piece, piece_valid, busy, bag_count);
      else n_pass++;
    end
    restart = 1'b0;
    @(negedge clka);
    n_checks++; if (lfsr_state !== 16'hE270) $display("FAIL first_step got=%h exp=e270", lfsr_state); else n_pass++;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clka);
      n_checks++; if (lfsr_state !== mdl_lfsr) $display("FAIL lfsr_track cyc=%0d got=%h exp=%h", i, lfsr_state, mdl_lfsr); else n_pass++;
    end
  endtask

  task automatic test_bag();
    logic [2:0] got, ep;
    int lat, el, cnt;
    bit bok;
    bit seen [NP];
    mode = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (i % NP == 0) for (int j = 0; j < NP; j++) seen[j] = 1'b0;
      do_req(1'b1, got, lat, ep, el, bok);
      n_checks++; if (got !== ep) $display("FAIL bag_piece req=%0d got=%0d exp=%0d", i, got, ep); else n_pass++;
      n_checks++; if (lat != el) $display("FAIL bag_latency req=%0d got=%0d exp=%0d", i, lat, el); else n_pass++;
      n_checks++; if (!bok || lat > 9) $display("FAIL bag_busy req=%0d busy_ok=%0d lat=%0d exp busy<=8", i, bok, lat); else n_pass++;
      n_checks++; if (bag_count !== 3'((i + 1) % NP)) $display("FAIL bag_count req=%0d got=%0d exp=%0d", i, bag_count, (i + 1) % NP); else n_pass++;
      if (int'(got) < NP) seen[got] = 1'b1;
      if (i % NP == NP - 1) begin
        cnt = 0;
        for (int j = 0; j < NP; j++) cnt += int'(seen[j]);
        n_checks++; if (cnt != NP) $display("FAIL bag_perm group=%0d distinct=%0d exp=%0d", i / NP, cnt, NP); else n_pass++;
      end
    end
  endtask

  task automatic test_uniform();
    logic [2:0] got, ep;
    int lat, el, frozen;
    bit bok;
    int hist [8];
    for (int i = 0; i < 8; i++) hist[i] = 0;
    mode = 1'b1;
    repeat (3) do_req(1'b1, got, lat, ep, el, bok);
    frozen = mdl_pop();
    mode = 1'b0;
    for (int i = 0; i < 500; i++) begin
      do_req(1'b0, got, lat, ep, el, bok);
      hist[got]++;
      n_checks++; if (int'(got) >= NP || got !== ep) $display("FAIL uni_piece req=%0d got=%0d exp=%0d", i, got, ep); else n_pass++;
      n_checks++; if (lat != el || lat < 2 || lat > 9) $display("FAIL uni_latency req=%0d got=%0d exp=%0d", i, lat, el); else n_pass++;
      n_checks++; if (bag_count !== 3'(frozen)) $display("FAIL uni_bag_frozen req=%0d got=%0d exp=%0d", i, bag_count, frozen); else n_pass++;
    end
    for (int k = 0; k < NP; k++) begin
      n_checks++; if (hist[k] == 0) $display("FAIL uni_coverage idx=%0d got=0 exp>0", k); else n_pass++;
    end
  endtask

  // Cycle-level abstract model: rem = SCAN cycles left, pv_exp = pulse due now.
  task automatic test_back_to_back();
    int rem = 0, accepts = 0, pulses = 0;
    bit pv_exp = 1'b0;
    logic [2:0] ep = 3'd0;
    mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clka);
      if (piece_valid === 1'b1) pulses++;
      n_checks++; if (piece_valid !== pv_exp) $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, piece_valid, pv_exp); else n_pass++;
      n_checks++; if (busy !== (rem > 0)) $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", i, busy, rem > 0); else n_pass++;
      if (pv_exp) begin
        n_checks++; if (piece !== ep) $display("FAIL b2b_piece cyc=%0d got=%0d exp=%0d", i, piece, ep); else n_pass++;
        n_checks++; if (bag_count !== 3'(mdl_pop())) $display("FAIL b2b_bag cyc=%0d got=%0d exp=%0d", i, bag_count, mdl_pop()); else n_pass++;
      end
      next_req = (i == 0) || (i >= 2 && i < 12);
      if (rem > 0) begin
        rem--;
        pv_exp = (rem == 0);
        if (rem == 0) begin
          mdl_take(ep);
          accepts++;
        end
      end else begin
        if (next_req && !pv_exp) rem = scan_steps(mdl_lfsr[2:0], 1'b1, ep);
        pv_exp = 1'b0;
      end
    end
    next_req = 1'b0;
    n_checks++; if (pulses != accepts || accepts < 2) $display("FAIL b2b_pulse_count got=%0d exp=%0d", pulses, accepts); else n_pass++;
  endtask

  task automatic test_restart_mid_scan();
    logic [2:0] got, ep;
    int lat, el, cnt;
    bit bok;
    bit seen [NP];
    @(negedge clka); restart = 1'b1;
    @(negedge clka); restart = 1'b0;
    mdl_clear();
    mode = 1'b1;
    repeat (3) begin
      do_req(1'b1, got, lat, ep, el, bok);
      n_checks++; if (got !== ep) $display("FAIL rst_pre_piece got=%0d exp=%0d", got, ep); else n_pass++;
    end
    @(negedge clka); next_req = 1'b1;
    @(negedge clka); next_req = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_in_scan busy got=%b exp=1", busy); else n_pass++;
    restart = 1'b1; entropy_strobe = 1'b1; entropy_in = 4'h5;
    @(negedge clka);
    n_checks++; if (piece_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_abort pv=%b busy=%b exp 0 0", piece_valid, busy); else n_pass++;
    n_checks++; if (bag_count !== 3'd0) $display("FAIL rst_bag got=%0d exp=0", bag_count); else n_pass++;
    n_checks++; if (lfsr_state !== SEED) $display("FAIL rst_lfsr got=%h exp=%h", lfsr_state, SEED); else n_pass++;
    restart = 1'b0;
    mdl_clear();
    @(negedge clka);
    entropy_strobe = 1'b0;
    n_checks++; if (lfsr_state !== 16'hE275) $display("FAIL rst_release_entropy got=%h exp=e275", lfsr_state); else n_pass++;
    n_checks++; if (piece_valid !== 1'b0) $display("FAIL rst_no_pulse got=%b exp=0", piece_valid); else n_pass++;
    for (int j = 0; j < NP; j++) seen[j] = 1'b0;
    for (int i = 0; i < NP; i++) begin
      do_req(1'b1, got, lat, ep, el, bok);
      n_checks++; if (got !== ep || lat != el) $display("FAIL rst_post_draw req=%0d got=%0d/%0d exp=%0d/%0d", i, got, lat, ep, el); else n_pass++;
      if (int'(got) < NP) seen[got] = 1'b1;
    end
    cnt = 0;
    for (int j = 0; j < NP; j++) cnt += int'(seen[j]);
    n_checks++; if (cnt != NP) $display("FAIL rst_post_perm distinct=%0d exp=%0d", cnt, NP); else n_pass++;
  endtask

  task automatic test_entropy_lockup();
    bit lock_pending = 1'b0, lock_done = 1'b0;
    logic [15:0] g;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clka);
      n_checks++; if (lfsr_state === 16'h0000 || lfsr_state !== mdl_lfsr)
        $display("FAIL ent_track cyc=%0d got=%h exp=%h", i, lfsr_state, mdl_lfsr);
      else n_pass++;
      if (lock_pending) begin
        n_checks++; if (lfsr_state !== SEED) $display("FAIL ent_lockup got=%h exp=%h", lfsr_state, SEED); else n_pass++;
        lock_pending = 1'b0;
        lock_done = 1'b1;
      end
      g = galois(mdl_lfsr);
      if (!lock_done && !lock_pending && g[15:4] == 12'h000) begin
        entropy_strobe = 1'b1;
        entropy_in = g[3:0];
        lock_pending = 1'b1;
      end else if (lock_done && $urandom_range(0, 7) == 0) begin
        entropy_strobe = 1'b1;
        entropy_in = 4'($urandom_range(1, 15));
      end else begin
        entropy_strobe = 1'b0;
      end
    end
    entropy_strobe = 1'b0;
    n_checks++; if (!lock_done) $display("FAIL ent_lockup_reached got=0 exp=1"); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bag();
    test_uniform();
    test_back_to_back();
    test_restart_mid_scan();
    test_entropy_lockup();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
